// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb - integer register file with a per-register pending scoreboard.
//
// NREGS x XLEN storage with NREAD combinational read ports and one
// synchronous write-back port. Each register carries a pending bit that is
// set when a producer issues (iss_we/iss_rd) and cleared when that
// producer writes back (rd_we/rd). Decode uses rs_busy to detect RAW
// hazards. Register 0 is hardwired to zero and is never pending.
//
// Optional build macro:
//   REGFILE_BYPASS_EN - forward the write-back value (and the resulting
//                       pending state) to a read port that addresses the
//                       register being written in the same cycle.
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   rst       in   asynchronous active-low reset
//   rs        in   NREAD*AW packed read addresses, port i at [i*AW +: AW]
//   rs_out    out  NREAD*XLEN packed read data, port i at [i*XLEN +: XLEN]
//   rs_busy   out  NREAD pending bit of each read-port register
//   rd        in   write-back address
//   rd_in     in   write-back data
//   rd_we     in   write-back enable
//   iss_rd    in   destination of the instruction issuing this cycle
//   iss_we    in   mark iss_rd pending
//   flush     in   clear all pending bits, register data is kept
//   busy_cnt  out  number of registers currently pending (registered)
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NREAD = 2,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   rs,
    output logic [NREAD*XLEN-1:0] rs_out,
    output logic [NREAD-1:0]      rs_busy,
    input  logic [AW-1:0]         rd,
    input  logic [XLEN-1:0]       rd_in,
    input  logic                  rd_we,
    input  logic [AW-1:0]         iss_rd,
    input  logic                  iss_we,
    input  logic                  flush,
    output logic [AW:0]           busy_cnt
);

    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_next;
    logic [CW-1:0]    cnt_next;

    logic wr_ok;     // effective write-back (never to register 0)
    logic iss_ok;    // effective issue mark (flush wins over issue)
    logic cnt_inc;   // a clear pending bit becomes set
    logic cnt_dec;   // a set pending bit is cleared by write-back

    assign wr_ok  = rd_we && (rd != '0);
    assign iss_ok = iss_we && (iss_rd != '0) && !flush;

    // Next pending vector: flush clears all, otherwise write-back clears and
    // issue sets, with the issue (newer producer) winning on a collision.
    always_comb begin
        pend_next = pend;
        if (flush) begin
            pend_next = '0;
        end else begin
            if (wr_ok) begin
                pend_next[rd] = 1'b0;
            end
            if (iss_ok) begin
                pend_next[iss_rd] = 1'b1;
            end
        end
        pend_next[0] = 1'b0;
    end

    // Counter deltas track only real transitions of the pending vector, so
    // busy_cnt stays equal to popcount(pend) without an adder tree.
    always_comb begin
        cnt_inc = iss_ok && !pend[iss_rd];
        cnt_dec = wr_ok && !flush && pend[rd] && !(iss_ok && (iss_rd == rd));
    end

    always_comb begin
        cnt_next = busy_cnt;
        if (flush) begin
            cnt_next = '0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   cnt_next = busy_cnt + CW'(1);
                2'b01:   cnt_next = busy_cnt - CW'(1);
                default: cnt_next = busy_cnt;
            endcase
        end
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend     <= '0;
            busy_cnt <= '0;
        end else begin
            pend     <= pend_next;
            busy_cnt <= cnt_next;
        end
    end

    // Register storage; entry 0 is only ever written by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            regs[rd] <= rd_in;
        end
    end

    // Combinational read ports.
    for (genvar g = 0; g < int'(NREAD); g++) begin : g_read
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr = rs[g*AW +: AW];

        always_comb begin
            data = (addr == '0) ? '0 : regs[addr];
            busy = pend[addr];
`ifdef REGFILE_BYPASS_EN
            // Write-through: report the value and pending state the register
            // will hold after this edge.
            if (wr_ok && (addr == rd)) begin
                data = rd_in;
                busy = iss_ok && (iss_rd == rd);
            end
`endif
        end

        assign rs_out[g*XLEN +: XLEN] = data;
        assign rs_busy[g]             = busy;
    end

endmodule
